// File: rtl/cpx_div_if.sv
// rtl/cpx_div_if.sv - operand/result bundle for the sequential complex divider.
interface cpx_div_if;
   logic        run;
   logic [15:0] ReA;
   logic [15:0] ImA;
   logic [15:0] ReB;
   logic [15:0] ImB;
   logic [31:0] ReY;
   logic [31:0] ImY;
   logic        busy;

   modport master (
      output run, ReA, ImA, ReB, ImB,
      input  ReY, ImY, busy
   );

   modport slave (
      input  run, ReA, ImA, ReB, ImB,
      output ReY, ImY, busy
   );
endinterface

// File: rtl/cpx_div.sv
// rtl/cpx_div.sv - sequential complex divider, Q8.8 operands to Q16.16 quotient.
// Products in one cycle, then 48 restoring iterations shared by both channels.
module cpx_div (
   input  logic     clock,
   input  logic     reset,
   cpx_div_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic signed [15:0] a_re_q, a_re_d;
   logic signed [15:0] a_im_q, a_im_d;
   logic signed [15:0] b_re_q, b_re_d;
   logic signed [15:0] b_im_q, b_im_d;
   logic [31:0]        den_q, den_d;
   logic               sign_re_q, sign_re_d;
   logic               sign_im_q, sign_im_d;
   logic [47:0]        num_re_q, num_re_d;
   logic [47:0]        num_im_q, num_im_d;
   logic [31:0]        rem_re_q, rem_re_d;
   logic [31:0]        rem_im_q, rem_im_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [31:0]        re_y_q, re_y_d;
   logic [31:0]        im_y_q, im_y_d;
   logic               busy_q, busy_d;

   logic signed [31:0] p_rr, p_ii, p_ir, p_ri, p_bb_r, p_bb_i;
   logic signed [32:0] n_re, n_im;
   logic [31:0]        den_w;
   logic [31:0]        mag_re, mag_im;

   // Every product fits 32 bits; only the sums need the extra sign bit.
   assign p_rr   = 32'(a_re_q) * 32'(b_re_q);
   assign p_ii   = 32'(a_im_q) * 32'(b_im_q);
   assign p_ir   = 32'(a_im_q) * 32'(b_re_q);
   assign p_ri   = 32'(a_re_q) * 32'(b_im_q);
   assign p_bb_r = 32'(b_re_q) * 32'(b_re_q);
   assign p_bb_i = 32'(b_im_q) * 32'(b_im_q);

   assign n_re   = 33'(p_rr) + 33'(p_ii);
   assign n_im   = 33'(p_ir) - 33'(p_ri);
   assign den_w  = $unsigned(p_bb_r) + $unsigned(p_bb_i);
   assign mag_re = n_re[32] ? 32'(-n_re) : 32'(n_re);
   assign mag_im = n_im[32] ? 32'(-n_im) : 32'(n_im);

   // One restoring step: returns {remainder, dividend/quotient shift register}.
   function automatic logic [79:0] div_step(input logic [31:0] rem,
                                            input logic [47:0] num,
                                            input logic [31:0] den);
      logic [32:0] sh;
      logic        ge;
      sh = {rem, num[47]};
      ge = (sh >= {1'b0, den});
      return {(ge ? 32'(sh - {1'b0, den}) : sh[31:0]), num[46:0], ge};
   endfunction

   function automatic logic [31:0] sat_sign(input logic neg, input logic [47:0] mag);
      if (!neg)
         return (mag > 48'h0000_7FFF_FFFF) ? 32'h7FFF_FFFF : mag[31:0];
      return (mag > 48'h0000_8000_0000) ? 32'h8000_0000 : (~mag[31:0] + 32'd1);
   endfunction

   always_comb begin
      state_d   = state_q;
      a_re_d    = a_re_q;
      a_im_d    = a_im_q;
      b_re_d    = b_re_q;
      b_im_d    = b_im_q;
      den_d     = den_q;
      sign_re_d = sign_re_q;
      sign_im_d = sign_im_q;
      num_re_d  = num_re_q;
      num_im_d  = num_im_q;
      rem_re_d  = rem_re_q;
      rem_im_d  = rem_im_q;
      cnt_d     = cnt_q;
      re_y_d    = re_y_q;
      im_y_d    = im_y_q;
      busy_d    = busy_q;

      case (state_q)
         S_IDLE: begin
            if (bus.run) begin
               a_re_d  = bus.ReA;
               a_im_d  = bus.ImA;
               b_re_d  = bus.ReB;
               b_im_d  = bus.ImB;
               busy_d  = 1'b1;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            den_d     = den_w;
            sign_re_d = n_re[32];
            sign_im_d = n_im[32];
            num_re_d  = {mag_re, 16'h0000};
            num_im_d  = {mag_im, 16'h0000};
            rem_re_d  = 32'd0;
            rem_im_d  = 32'd0;
            cnt_d     = 6'd0;
            state_d   = S_DIV;
         end
         S_DIV: begin
            {rem_re_d, num_re_d} = div_step(rem_re_q, num_re_q, den_q);
            {rem_im_d, num_im_d} = div_step(rem_im_q, num_im_q, den_q);
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd47)
               state_d = S_DONE;
         end
         S_DONE: begin
            // A zero divisor leaves an all-ones quotient behind; force zero instead.
            if (den_q == 32'd0) begin
               re_y_d = 32'd0;
               im_y_d = 32'd0;
            end else begin
               re_y_d = sat_sign(sign_re_q, num_re_q);
               im_y_d = sat_sign(sign_im_q, num_im_q);
            end
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_re_q    <= '0;
         a_im_q    <= '0;
         b_re_q    <= '0;
         b_im_q    <= '0;
         den_q     <= '0;
         sign_re_q <= 1'b0;
         sign_im_q <= 1'b0;
         num_re_q  <= '0;
         num_im_q  <= '0;
         rem_re_q  <= '0;
         rem_im_q  <= '0;
         cnt_q     <= '0;
         re_y_q    <= '0;
         im_y_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_re_q    <= a_re_d;
         a_im_q    <= a_im_d;
         b_re_q    <= b_re_d;
         b_im_q    <= b_im_d;
         den_q     <= den_d;
         sign_re_q <= sign_re_d;
         sign_im_q <= sign_im_d;
         num_re_q  <= num_re_d;
         num_im_q  <= num_im_d;
         rem_re_q  <= rem_re_d;
         rem_im_q  <= rem_im_d;
         cnt_q     <= cnt_d;
         re_y_q    <= re_y_d;
         im_y_q    <= im_y_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.ReY  = re_y_q;
   assign bus.ImY  = im_y_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_cpx_div.sv
// tb/tb_cpx_div.sv - scoreboard bench for the sequential complex divider.
module tb_cpx_div;

   logic clock = 1'b0;
   logic reset = 1'b0;

   cpx_div_if bus ();

   cpx_div dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int          checks    = 0;
   int          failures  = 0;
   int          done_cnt  = 0;
   int          busy_cnt  = 0;
   int          n_started = 0;
   logic        busy_prev = 1'b0;
   logic [63:0] exp_v;
   logic [63:0] sb_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] q16(input longint n, input longint d);
      longint mag, q;
      if (d == 0) return 32'd0;
      mag = (n < 0) ? -n : n;
      q   = (mag * 65536) / d;
      if (n < 0)
         return (q > 64'sd2147483648) ? 32'h8000_0000 : 32'(-q);
      return (q > 64'sd2147483647) ? 32'h7FFF_FFFF : 32'(q);
   endfunction

   function automatic logic [63:0] model(input logic [15:0] ar, input logic [15:0] ai,
                                         input logic [15:0] br, input logic [15:0] bi);
      longint sar, sai, sbr, sbi;
      sar = longint'($signed(ar));
      sai = longint'($signed(ai));
      sbr = longint'($signed(br));
      sbi = longint'($signed(bi));
      return {q16(sar * sbr + sai * sbi, sbr * sbr + sbi * sbi),
              q16(sai * sbr - sar * sbi, sbr * sbr + sbi * sbi)};
   endfunction

   always @(posedge clock) begin
      #1;
      if (reset) begin
         busy_prev = 1'b0;
         busy_cnt  = 0;
      end else begin
         if (bus.busy) begin
            busy_cnt++;
         end else if (busy_prev) begin
            check_eq("busy_cycles", 64'(busy_cnt), 64'd50);
            check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               exp_v = sb_q.pop_front();
               check_eq("ReY", 64'(bus.ReY), 64'(exp_v[63:32]));
               check_eq("ImY", 64'(bus.ImY), 64'(exp_v[31:0]));
            end
            done_cnt++;
            busy_cnt = 0;
         end
         busy_prev = bus.busy;
      end
   end

   task automatic start_op(input logic [15:0] ar, input logic [15:0] ai,
                           input logic [15:0] br, input logic [15:0] bi,
                           input logic [63:0] exp);
      @(negedge clock);
      bus.ReA = ar;
      bus.ImA = ai;
      bus.ReB = br;
      bus.ImB = bi;
      bus.run = 1'b1;
      sb_q.push_back(exp);
      n_started++;
      @(negedge clock);
      bus.run = 1'b0;
      check_eq("busy_start", 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 400 && done_cnt < target; i++)
         @(negedge clock);
      check_eq("done_count", 64'(done_cnt), 64'(target));
   endtask

   initial begin
      bus.run = 1'b0;
      bus.ReA = '0;
      bus.ImA = '0;
      bus.ReB = '0;
      bus.ImB = '0;

      #2 reset = 1'b1;
      #1;
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_ReY", 64'(bus.ReY), 64'd0);
      check_eq("rst_ImY", 64'(bus.ImY), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      start_op(16'hFA80, 16'hF6B3, 16'h0100, 16'h0000, {32'hFFFA_8000, 32'hFFF6_B300});
      wait_done(n_started);
      start_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, {32'h0000_0000, 32'hFFFF_0000});
      wait_done(n_started);
      start_op(16'h8000, 16'h8000, 16'h0000, 16'h0001, {32'h8000_0000, 32'h7FFF_FFFF});
      wait_done(n_started);

      // Second run mid-operation must be ignored; outputs hold the previous result.
      start_op(16'h0100, 16'h0000, 16'h0200, 16'h0000, {32'h0000_8000, 32'h0000_0000});
      repeat (8) @(negedge clock);
      bus.ReA = 16'h7F00;
      bus.ReB = 16'h0100;
      bus.run = 1'b1;
      @(negedge clock);
      bus.run = 1'b0;
      check_eq("hold_ReY", 64'(bus.ReY), 64'h8000_0000);
      check_eq("hold_ImY", 64'(bus.ImY), 64'h7FFF_FFFF);
      wait_done(n_started);

      start_op(16'h0300, 16'h0000, 16'h0000, 16'h0000, 64'd0);
      wait_done(n_started);

      // run held high: second operation latches the operands present after the first ends.
      @(negedge clock);
      bus.ReA = 16'h0100;
      bus.ImA = 16'h0200;
      bus.ReB = 16'h0100;
      bus.ImB = 16'h0100;
      bus.run = 1'b1;
      sb_q.push_back({32'h0001_8000, 32'h0000_8000});
      @(negedge clock);
      bus.ReA = 16'h0400;
      bus.ImA = 16'h0000;
      bus.ReB = 16'hFE00;
      bus.ImB = 16'h0000;
      sb_q.push_back({32'hFFFE_0000, 32'h0000_0000});
      n_started += 2;
      wait_done(n_started);
      bus.run = 1'b0;

      for (int i = 0; i < 8; i++) begin
         logic [15:0] ar, ai, br, bi;
         ar = 16'($urandom);
         ai = 16'($urandom);
         br = (i % 2 == 1) ? 16'($urandom_range(0, 8)) : 16'($urandom);
         bi = (i % 2 == 1) ? 16'($urandom_range(0, 8)) : 16'($urandom);
         start_op(ar, ai, br, bi, model(ar, ai, br, bi));
         wait_done(n_started);
      end

      // Abort mid-divide; the dropped operation must never complete.
      start_op(16'h0100, 16'h0000, 16'h0100, 16'h0000, {32'h0001_0000, 32'h0000_0000});
      repeat (20) @(negedge clock);
      reset = 1'b1;
      #1;
      check_eq("abort_busy", 64'(bus.busy), 64'd0);
      check_eq("abort_ReY", 64'(bus.ReY), 64'd0);
      check_eq("abort_ImY", 64'(bus.ImY), 64'd0);
      sb_q.delete();
      n_started--;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      start_op(16'hFA80, 16'hF6B3, 16'h0100, 16'h0000, {32'hFFFA_8000, 32'hFFF6_B300});
      wait_done(n_started);
      repeat (3) @(negedge clock);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      check_eq("final_done", 64'(done_cnt), 64'(n_started));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
